mem_arbiter: RTL and testbench

Shares one single-port, variable-latency unified memory between the pipelined core's instruction-fetch requester and its memory-stage data requester. It arbitrates simultaneous requests, registers the winning request onto the memory port, waits for completion, and returns read data with a one-cycle ready pulse to the winner. The core stalls its fetch or memory stage on the missing ready pulse. The block sits between the core's fetch/data ports and the external memory model.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, DONE)
//   grant_t     : which requester owns the memory port
//   ADDR_W_DEF / DATA_W_DEF : default address/data widths
//   port_we()   : write enable to present on the memory port for a grant
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // Fetches never write; only a granted data request may carry a store.
  function automatic logic port_we(input grant_t grant, input logic d_we);
    return (grant == GRANT_DATA) && d_we;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, data and memory-side signals of the
// arbiter.
//   slave  : arbiter view (consumes requests and memory responses,
//            produces ready/rdata and the memory command)
//   master : environment view (core requesters plus memory model)
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data.
//   if_req, d_req : pending requests
//   last_grant    : previous winner (only when MEM_ARB_RR_EN is defined)
//   grant         : selected requester; meaningless when neither requests
// Default build: data always beats fetch. MEM_ARB_RR_EN: on a conflict the
// requester that did not win last time is chosen.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  grant_t last_grant,
`endif
  output grant_t grant
);

  // Winner selection; a lone request always wins.
  always_comb begin
    grant = GRANT_DATA;
    if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
      if (last_grant == GRANT_DATA) begin
        grant = GRANT_FETCH;
      end else begin
        grant = GRANT_DATA;
      end
`else
      grant = GRANT_DATA;
`endif
    end else if (if_req) begin
      grant = GRANT_FETCH;
    end else begin
      grant = GRANT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch and data requesters.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (fetch/data request+response, memory port)
// A request seen in IDLE is latched onto the memory port (BUSY) until
// mem_ready, then the winner gets a one-cycle ready pulse (DONE). DONE
// ignores requests so a request still held there is never issued twice.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  grant_t            pick_s;
  grant_t            grant_r;
  logic              grant_load_s;
  logic              mem_done_s;

  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              if_ready_r;
  logic              d_ready_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

`ifdef MEM_ARB_RR_EN
  grant_t            last_grant_r;

  // Remember the previous winner; starts at fetch so data wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= GRANT_FETCH;
    end else if (grant_load_s) begin
      last_grant_r <= pick_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  mem_arb_pick u_pick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant_r),
    .grant      (pick_s)
  );
`else
  mem_arb_pick u_pick (
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .grant  (pick_s)
  );
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic plus the grant-latch and completion strobes.
  always_comb begin
    next_state_s = state_r;
    grant_load_s = 1'b0;
    mem_done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          next_state_s = BUSY;
          grant_load_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          next_state_s = DONE;
          mem_done_s   = 1'b1;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Memory port registers: command latched at grant, held stable through BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      grant_r     <= GRANT_FETCH;
    end else begin
      mem_req_r <= (next_state_s == BUSY);
      if (grant_load_s) begin
        grant_r  <= pick_s;
        mem_we_r <= port_we(pick_s, bus.d_we);
        if (pick_s == GRANT_DATA) begin
          mem_addr_r  <= bus.d_addr;
          mem_wdata_r <= bus.d_wdata;
        end else begin
          mem_addr_r  <= bus.if_addr;
          mem_wdata_r <= mem_wdata_r;
        end
      end else if (mem_done_s) begin
        mem_we_r <= 1'b0;
      end else begin
        mem_we_r <= mem_we_r;
      end
    end
  end

  // Response registers: one-cycle ready pulse, rdata held until next load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready_r <= 1'b0;
      d_ready_r  <= 1'b0;
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      if_ready_r <= mem_done_s && (grant_r == GRANT_FETCH);
      d_ready_r  <= mem_done_s && (grant_r == GRANT_DATA);
      if (mem_done_s && (grant_r == GRANT_FETCH)) begin
        if_rdata_r <= bus.mem_rdata;
      end
      // Stores leave d_rdata untouched.
      if (mem_done_s && (grant_r == GRANT_DATA) && !mem_we_r) begin
        d_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_ready  = if_ready_r;
  assign bus.d_ready   = d_ready_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter. Expected
// responses are queued when a request is driven and popped by a monitor
// when a ready pulse appears.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   if_ready_cnt = 0;
  int   d_ready_cnt  = 0;
  int   acc_cnt      = 0;
  int   last_if_cyc  = -1;
  int   last_d_cyc   = -1;
  logic prev_mem_req = 1'b0;
  exp_t exp_q[$];

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: count accesses and ready pulses, compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && prev_mem_req !== 1'b1) acc_cnt++;
      prev_mem_req = bus.mem_req;
      if (bus.if_ready === 1'b1 || bus.d_ready === 1'b1) begin
        if (bus.if_ready === 1'b1) begin
          if_ready_cnt++;
          last_if_cyc = cyc;
        end
        if (bus.d_ready === 1'b1) begin
          d_ready_cnt++;
          last_d_cyc = cyc;
        end
        chk("dual_ready", {31'd0, bus.if_ready & bus.d_ready}, 32'd0);
        chk("ready_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ready_port", {31'd0, bus.d_ready}, {31'd0, e.is_data});
          chk("ready_rdata", e.is_data ? bus.d_rdata : bus.if_rdata, e.rdata);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Memory responder for one access: check the held command, then answer.
  task automatic serve(input int waits, input logic [31:0] rd, input logic [31:0] eaddr,
                       input logic ewe, input logic [31:0] ewdata,
                       output int req_cyc, output int rdy_cyc);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req_seen", {31'd0, bus.mem_req}, 32'd1);
    req_cyc = cyc;
    rdy_cyc = cyc;
    for (int w = 0; w <= waits; w++) begin
      chk("mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
      chk("mem_addr", bus.mem_addr, eaddr);
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, ewe});
      if (ewe) chk("mem_wdata", bus.mem_wdata, ewdata);
      if (w == waits) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        rdy_cyc = cyc;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h5A5A_5A5A;
    chk("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
    #1;
  endtask

  // Directed sequence.
  initial begin
    int c0, rq, rd, a0, ic, dc;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'd0;
    bus.d_wdata   = 32'd0;
    bus.mem_rdata = 32'd0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_mem_req",   {31'd0, bus.mem_req},  32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
    chk("rst_mem_addr",  bus.mem_addr,          32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,         32'd0);
    chk("rst_if_ready",  {31'd0, bus.if_ready}, 32'd0);
    chk("rst_d_ready",   {31'd0, bus.d_ready},  32'd0);
    chk("rst_if_rdata",  bus.if_rdata,          32'd0);
    chk("rst_d_rdata",   bus.d_rdata,           32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Lone fetch, zero-wait memory.
    c0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    exp_q.push_back('{1'b0, 32'h0050_0093});
    serve(0, 32'h0050_0093, 32'h0000_0100, 1'b0, 32'd0, rq, rd);
    bus.if_req = 1'b0;
    chk("t1_req_cycle",   rq,           c0 + 1);
    chk("t1_ready_cycle", last_if_cyc,  c0 + 2);
    chk("t1_if_rdata",    bus.if_rdata, 32'h0050_0093);
    chk("t1_no_d_ready",  d_ready_cnt,  32'd0);

    // Simultaneous fetch and load: data served first.
    @(negedge clk);
    c0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_2000;
    exp_q.push_back('{1'b1, 32'h1111_2222});
    exp_q.push_back('{1'b0, 32'h3333_4444});
    serve(0, 32'h1111_2222, 32'h0000_2000, 1'b0, 32'd0, rq, rd);
    bus.d_req = 1'b0;
    serve(0, 32'h3333_4444, 32'h0000_0104, 1'b0, 32'd0, rq, rd);
    bus.if_req = 1'b0;
    chk("t2_d_cycle",   last_d_cyc,   c0 + 2);
    chk("t2_if_cycle",  last_if_cyc,  c0 + 5);
    chk("t2_d_count",   d_ready_cnt,  32'd1);
    chk("t2_if_count",  if_ready_cnt, 32'd2);

    // Store with 3 wait states.
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_2004;
    bus.d_wdata = 32'hDEAD_BEEF;
    exp_q.push_back('{1'b1, 32'h1111_2222});
    serve(3, 32'hCAFE_F00D, 32'h0000_2004, 1'b1, 32'hDEAD_BEEF, rq, rd);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    chk("t3_ready_lat", last_d_cyc,  rd + 1);
    chk("t3_d_rdata",   bus.d_rdata, 32'h1111_2222);
    chk("t3_we_clear",  {31'd0, bus.mem_we}, 32'd0);

    // Request held through DONE, dropped in the following cycle.
    @(negedge clk);
    a0 = acc_cnt;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_2008;
    exp_q.push_back('{1'b1, 32'h5566_7788});
    serve(0, 32'h5566_7788, 32'h0000_2008, 1'b0, 32'd0, rq, rd);
    @(negedge clk);
    bus.d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_one_access", acc_cnt - a0, 32'd1);
    chk("t4_d_rdata",    bus.d_rdata,  32'h5566_7788);

    // mem_ready outside BUSY is ignored.
    ic = if_ready_cnt;
    dc = d_ready_cnt;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("t5_no_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("t5_no_ready",    (if_ready_cnt - ic) + (d_ready_cnt - dc), 32'd0);
    chk("t5_if_rdata",    bus.if_rdata, 32'h3333_4444);

    // Reset mid-BUSY abandons the access.
    ic = if_ready_cnt;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0500;
    @(negedge clk);
    chk("t6_busy",        {31'd0, bus.mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_req",   {31'd0, bus.mem_req},  32'd0);
    chk("t6_async_ready", {31'd0, bus.if_ready}, 32'd0);
    chk("t6_async_rdata", bus.if_rdata,          32'd0);
    @(negedge clk);
    bus.if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_ready",    if_ready_cnt - ic, 32'd0);
    c0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0600;
    exp_q.push_back('{1'b0, 32'h0A0B_0C0D});
    serve(1, 32'h0A0B_0C0D, 32'h0000_0600, 1'b0, 32'd0, rq, rd);
    bus.if_req = 1'b0;
    chk("t6_after_cycle", last_if_cyc,  c0 + 3);
    chk("t6_after_rdata", bus.if_rdata, 32'h0A0B_0C0D);

    // Both requesters held for 4 accesses.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0400;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_3000;
    for (int k = 0; k < 4; k++) begin
      logic g_data;
      g_data = RR ? ((k % 2) == 0) : 1'b1;
      exp_q.push_back('{g_data, 32'h7000_0000 + k});
      serve(0, 32'h7000_0000 + k, g_data ? 32'h0000_3000 : 32'h0000_0400,
            1'b0, 32'd0, rq, rd);
      if (k == 3) begin
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("idle_at_end",   {31'd0, bus.mem_req}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
